// File: rtl/spi_bus_pkg.sv
// spi_bus_pkg
//   Shared types and constants for the SPI bus arbiter:
//   - spi_bus_state_t : arbiter FSM state encoding
//   - SPI_BYTE_W      : width of one SPI transfer
//   - RST_*           : values the registers take while reset is asserted
//   - max_int         : elaboration-time helper for sizing counters
package spi_bus_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } spi_bus_state_t;

  localparam spi_bus_state_t            RST_STATE = ST_IDLE;
  localparam logic [SPI_BYTE_W-1:0]     RST_BYTE  = '0;
  localparam logic                      RST_PULSE = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. Scans the request vector starting at
//   i_ptr and wrapping around; the first active request wins.
//   Ports:
//     i_req     [NREQ-1:0]   request vector
//     i_ptr     [IDX_W-1:0]  index with the highest priority this round
//     o_win     [NREQ-1:0]   one-hot winner, zero when no request
//     o_win_idx [IDX_W-1:0]  binary index of the winner (0 when no request)
//   The pointer register is owned by the instantiating module.
module rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_win,
  output logic [IDX_W-1:0] o_win_idx
);

  always_comb begin
    int   w_idx;
    logic w_found;
    o_win     = '0;
    o_win_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int off = 0; off < NREQ; off++) begin
      // i_ptr is always a legal index, so a single subtraction wraps it.
      w_idx = int'(i_ptr) + off;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_win[w_idx]   = 1'b1;
        o_win_idx      = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
//   Shares one single-byte SPI engine between NREQ requesters. A requester is
//   granted for a whole frame; its active-low chip select is driven with a
//   setup delay before the first byte and a hold delay after the last one.
//   Ports:
//     clk, reset             clock, asynchronous active-low reset
//     req[NREQ]              frame request, held for the whole frame
//     gnt[NREQ]              one-hot grant (zero when idle)
//     tx_data[NREQ*8]        per-requester byte, slice [8i+7:8i]
//     tx_valid/tx_last[NREQ] per-requester byte valid / final-byte marker
//     tx_ready               accept strobe for the granted requester
//     rx_data, rx_valid      received byte and its one-cycle strobe
//     cs_n[NREQ]             per-device chip select, active low
//     eng_start, eng_din     start pulse and byte to the engine
//     eng_busy, eng_done,    engine status, completion pulse and
//     eng_dout               received byte
//     dbg_state              current FSM state
//
//   Handshake: a byte moves from the granted requester g when
//   tx_valid[g] && tx_ready are both high on a rising edge. tx_ready is only
//   ever high in XFER, so no other state can accept. Non-granted tx_* inputs
//   are never looked at.
module spi_bus_arbiter
  import spi_bus_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  output logic [NREQ-1:0]            gnt,
  input  logic [NREQ*SPI_BYTE_W-1:0] tx_data,
  input  logic [NREQ-1:0]            tx_valid,
  input  logic [NREQ-1:0]            tx_last,
  output logic                       tx_ready,
  output logic [SPI_BYTE_W-1:0]      rx_data,
  output logic                       rx_valid,
  output logic [NREQ-1:0]            cs_n,
  output logic                       eng_start,
  output logic [SPI_BYTE_W-1:0]      eng_din,
  input  logic                       eng_busy,
  input  logic                       eng_done,
  input  logic [SPI_BYTE_W-1:0]      eng_dout,
  output spi_bus_state_t             dbg_state
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(max_int(CS_SETUP, CS_HOLD) + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD - 1);

  spi_bus_state_t          r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [NREQ-1:0]         r_gnt;
  logic [NREQ-1:0]         r_cs_n;
  logic [IDX_W-1:0]        r_gidx;
  logic [IDX_W-1:0]        r_ptr;
  logic                    r_last;
  logic                    r_drop;
  logic                    r_tx_ready;
  logic                    r_eng_start;
  logic [SPI_BYTE_W-1:0]   r_eng_din;
  logic [SPI_BYTE_W-1:0]   r_rx_data;
  logic                    r_rx_valid;

  logic [NREQ-1:0]         w_win;
  logic [IDX_W-1:0]        w_win_idx;
  logic                    w_any_req;
  logic                    w_req_g;
  logic                    w_valid_g;
  logic                    w_last_g;
  logic [SPI_BYTE_W-1:0]   w_byte_g;
  logic                    w_accept;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_win_idx (w_win_idx)
  );

  assign w_any_req = |req;

  // Select the granted requester's inputs by its registered index.
  always_comb begin
    w_req_g   = 1'b0;
    w_valid_g = 1'b0;
    w_last_g  = 1'b0;
    w_byte_g  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gidx == IDX_W'(i)) begin
        w_req_g   = req[i];
        w_valid_g = tx_valid[i];
        w_last_g  = tx_last[i];
        w_byte_g  = tx_data[i*SPI_BYTE_W +: SPI_BYTE_W];
      end
    end
  end

  assign w_accept = r_tx_ready & w_valid_g;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RST_STATE;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_cs_n      <= '1;
      r_gidx      <= '0;
      r_ptr       <= '0;
      r_last      <= 1'b0;
      r_drop      <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_eng_start <= RST_PULSE;
      r_eng_din   <= RST_BYTE;
      r_rx_data   <= RST_BYTE;
      r_rx_valid  <= RST_PULSE;
    end else begin
      r_eng_start <= 1'b0;
      r_rx_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state <= ST_SETUP;
            r_gnt   <= w_win;
            r_cs_n  <= ~w_win;
            r_gidx  <= w_win_idx;
            r_cnt   <= SETUP_LOAD;
            r_last  <= 1'b0;
            r_drop  <= 1'b0;
          end
        end

        ST_SETUP: begin
          if (!w_req_g) begin
            r_state <= ST_HOLD;
            r_cnt   <= HOLD_LOAD;
          end else if (r_cnt == '0) begin
            r_state    <= ST_XFER;
            r_tx_ready <= ~eng_busy;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_XFER: begin
          if (!w_req_g) begin
            // Abandoned frame: a same-cycle tx_valid is not taken.
            r_state    <= ST_HOLD;
            r_tx_ready <= 1'b0;
            r_cnt      <= HOLD_LOAD;
          end else if (w_accept) begin
            r_state     <= ST_WAIT;
            r_tx_ready  <= 1'b0;
            r_eng_start <= 1'b1;
            r_eng_din   <= w_byte_g;
            r_last      <= w_last_g;
            r_drop      <= 1'b0;
          end else begin
            // tx_ready tracks the engine one cycle late, so a busy engine
            // never sees a start it cannot take.
            r_tx_ready <= ~eng_busy;
          end
        end

        ST_WAIT: begin
          // Remember a drop even if req comes back before the byte ends.
          if (!w_req_g) r_drop <= 1'b1;
          if (eng_done) begin
            r_rx_data  <= eng_dout;
            r_rx_valid <= 1'b1;
            if (r_last || r_drop || !w_req_g) begin
              r_state <= ST_HOLD;
              r_cnt   <= HOLD_LOAD;
            end else begin
              r_state    <= ST_XFER;
              r_tx_ready <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_cs_n  <= '1;
            r_ptr   <= (r_gidx == IDX_W'(NREQ - 1)) ? '0 : r_gidx + IDX_W'(1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_gnt      <= '0;
          r_cs_n     <= '1;
          r_tx_ready <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign cs_n      = r_cs_n;
  assign tx_ready  = r_tx_ready;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign eng_start = r_eng_start;
  assign eng_din   = r_eng_din;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter
//   Directed bench for spi_bus_arbiter with a fixed-latency byte engine model.
module tb_spi_bus_arbiter;
  import spi_bus_pkg::*;

  localparam int NREQ     = 4;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int ENG_LAT  = 3;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic [NREQ*8-1:0] tx_data;
  logic [NREQ-1:0]   tx_valid;
  logic [NREQ-1:0]   tx_last;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [NREQ-1:0]   cs_n;
  logic              eng_start;
  logic [7:0]        eng_din;
  logic              eng_busy;
  logic              eng_done;
  logic [7:0]        eng_dout;
  spi_bus_state_t    dbg_state;

  logic       mdl_busy, mdl_done, man_busy, man_done;
  logic [7:0] mdl_dout;
  assign eng_busy = mdl_busy | man_busy;
  assign eng_done = mdl_done | man_done;
  assign eng_dout = mdl_dout;

  spi_bus_arbiter #(.NREQ(NREQ), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cs_n      (cs_n),
    .eng_start (eng_start),
    .eng_din   (eng_din),
    .eng_busy  (eng_busy),
    .eng_done  (eng_done),
    .eng_dout  (eng_dout),
    .dbg_state (dbg_state)
  );

  // scoreboard state
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] resp_q[$];
  logic [7:0] din_log[$];
  logic [7:0] rx_log[$];
  int         gnt_log[$];
  int         gap_err       = 0;
  int         n_start       = 0;
  int         last_done_cyc = 0;
  int         cs_rise_cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // byte engine model: busy for ENG_LAT cycles after a start, then done
  initial begin
    mdl_busy = 1'b0;
    mdl_done = 1'b0;
    mdl_dout = 8'h00;
    forever begin
      @(negedge clk);
      mdl_done = 1'b0;
      if (eng_start === 1'b1) begin
        mdl_busy = 1'b1;
        repeat (ENG_LAT) @(negedge clk);
        mdl_busy = 1'b0;
        mdl_done = 1'b1;
        if (resp_q.size() > 0) mdl_dout = resp_q.pop_front();
        else mdl_dout = 8'hEE;
        last_done_cyc = cyc;
      end
    end
  end

  // monitor
  initial begin
    logic [NREQ-1:0] prev_gnt;
    logic [NREQ-1:0] prev_cs;
    prev_gnt = '0;
    prev_cs  = '1;
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) rx_log.push_back(rx_data);
      if (eng_start === 1'b1) begin
        din_log.push_back(eng_din);
        n_start++;
      end
      if (gnt !== prev_gnt && gnt !== '0) begin
        for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
        if (prev_gnt !== '0) gap_err++;
      end
      if ((~prev_cs & cs_n) != '0) cs_rise_cyc = cyc;
      prev_gnt = gnt;
      prev_cs  = cs_n;
    end
  end

  // driver tasks
  task automatic send_byte(input int r, input logic [7:0] d, input logic last);
    int n = 0;
    tx_data[r*8 +: 8] = d;
    tx_valid[r] = 1'b1;
    tx_last[r]  = last;
    while (tx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", tx_ready, 1'b1);
    @(negedge clk);
    tx_valid[r] = 1'b0;
    tx_last[r]  = 1'b0;
    check("start_pulse", eng_start, 1'b1);
    check("start_din", eng_din, d);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dbg_state !== ST_IDLE && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, dbg_state, ST_IDLE);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, tx_ready, 1'b1);
  endtask

  task automatic clear_logs();
    din_log.delete();
    rx_log.delete();
    gnt_log.delete();
    resp_q.delete();
    gap_err = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // main sequence
  initial begin
    int n, base, bad, base_rx;
    reset    = 1'b0;
    req      = '0;
    tx_data  = '0;
    tx_valid = '0;
    tx_last  = '0;
    man_busy = 1'b0;
    man_done = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_cs_n", cs_n, 4'b1111);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_eng_start", eng_start, 1'b0);
    check("rst_eng_din", eng_din, 8'h00);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b1;
    @(negedge clk);

    // single three-byte frame on requester 1
    clear_logs();
    resp_q = '{8'h41, 8'h5A, 8'hFF};
    req[1] = 1'b1;
    @(negedge clk);
    check("t1_gnt", gnt, 4'b0010);
    check("t1_cs_n", cs_n, 4'b1101);
    check("t1_state_setup", dbg_state, ST_SETUP);
    repeat (CS_SETUP - 1) @(negedge clk);
    check("t1_ready_early", tx_ready, 1'b0);
    @(negedge clk);
    check("t1_ready_first", tx_ready, 1'b1);
    send_byte(1, 8'h01, 1'b0);
    check("t1_ready_low_after_accept", tx_ready, 1'b0);
    send_byte(1, 8'h42, 1'b0);
    send_byte(1, 8'h00, 1'b1);
    wait_idle("t1_idle");
    req[1] = 1'b0;
    @(negedge clk);
    check("t1_din_cnt", din_log.size(), 3);
    check("t1_rx_cnt", rx_log.size(), 3);
    check("t1_rx0", (rx_log.size() > 0) ? rx_log[0] : 8'hXX, 8'h41);
    check("t1_rx1", (rx_log.size() > 1) ? rx_log[1] : 8'hXX, 8'h5A);
    check("t1_rx2", (rx_log.size() > 2) ? rx_log[2] : 8'hXX, 8'hFF);
    check("t1_cs_hold", cs_rise_cyc - last_done_cyc, CS_HOLD + 1);
    check("t1_cs_n_end", cs_n, 4'b1111);

    // round robin with all requesters held
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_logs();
    tx_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tx_valid = '1;
    tx_last  = '1;
    req      = '1;
    n = 0;
    while (gnt_log.size() < 5 && n < 400) begin
      @(negedge clk);
      n++;
    end
    req      = '0;
    tx_valid = '0;
    tx_last  = '0;
    wait_idle("rr_idle");
    @(negedge clk);
    check("rr_grants", gnt_log.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("rr_order%0d", i), (gnt_log.size() > i) ? gnt_log[i] : 99, i % 4);
    check("rr_gap", gap_err, 0);
    check("rr_din_cnt", din_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_din%0d", i), (din_log.size() > i) ? din_log[i] : 8'hXX, 8'hA0 + i);

    // stall: tx_valid low for 20 cycles in XFER
    clear_logs();
    resp_q = '{8'h3C};
    req[3] = 1'b1;
    wait_ready("stall_ready_up");
    base = n_start;
    bad  = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_ready !== 1'b1) bad++;
    end
    check("stall_ready_held", bad, 0);
    check("stall_no_start", n_start - base, 0);
    send_byte(3, 8'h99, 1'b1);
    wait_idle("stall_idle");
    req[3] = 1'b0;
    @(negedge clk);
    check("stall_one_start", n_start - base, 1);
    check("stall_rx", (rx_log.size() > 0) ? rx_log[0] : 8'hXX, 8'h3C);

    // early drop of req[2] during WAIT
    clear_logs();
    resp_q = '{8'h77};
    base   = n_start;
    req[2] = 1'b1;
    tx_data[2*8 +: 8] = 8'h33;
    tx_valid[2] = 1'b1;
    tx_last[2]  = 1'b0;
    wait_ready("drop_ready");
    @(negedge clk);
    check("drop_start", eng_start, 1'b1);
    check("drop_din", eng_din, 8'h33);
    check("drop_state_wait", dbg_state, ST_WAIT);
    req[2] = 1'b0;
    tx_data[2*8 +: 8] = 8'h34;
    n = 0;
    while (rx_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drop_rx_valid", rx_valid, 1'b1);
    check("drop_rx_data", rx_data, 8'h77);
    check("drop_state_hold", dbg_state, ST_HOLD);
    wait_idle("drop_idle");
    tx_valid[2] = 1'b0;
    @(negedge clk);
    check("drop_one_start", n_start - base, 1);
    check("drop_cs_hold", cs_rise_cyc - last_done_cyc, CS_HOLD + 1);
    check("drop_cs_n", cs_n, 4'b1111);

    // asynchronous reset while in WAIT
    clear_logs();
    resp_q = '{8'h55};
    req[0] = 1'b1;
    send_byte(0, 8'h11, 1'b0);
    @(negedge clk);
    check("rwait_state", dbg_state, ST_WAIT);
    #2;
    reset = 1'b0;
    #1;
    check("rwait_cs_n", cs_n, 4'b1111);
    check("rwait_gnt", gnt, 4'b0000);
    check("rwait_state_idle", dbg_state, ST_IDLE);
    check("rwait_eng_din", eng_din, 8'h00);
    req[0]  = 1'b0;
    base_rx = rx_log.size();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rwait_no_rx", rx_log.size() - base_rx, 0);
    check("rwait_still_idle", dbg_state, ST_IDLE);

    // engine busy on entry to XFER
    clear_logs();
    resp_q   = '{8'hC5};
    base     = n_start;
    man_busy = 1'b1;
    tx_data[1*8 +: 8] = 8'h5C;
    tx_valid[1] = 1'b1;
    tx_last[1]  = 1'b1;
    req[1]      = 1'b1;
    repeat (CS_SETUP + 1) @(negedge clk);
    check("busy_state_xfer", dbg_state, ST_XFER);
    check("busy_ready_low", tx_ready, 1'b0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_ready !== 1'b0) bad++;
    end
    check("busy_ready_held_low", bad, 0);
    check("busy_no_start", n_start - base, 0);
    man_busy = 1'b0;
    @(negedge clk);
    check("busy_ready_up", tx_ready, 1'b1);
    @(negedge clk);
    check("busy_start", eng_start, 1'b1);
    check("busy_din", eng_din, 8'h5C);
    tx_valid[1] = 1'b0;
    tx_last[1]  = 1'b0;
    wait_idle("busy_idle");
    req[1] = 1'b0;
    @(negedge clk);
    check("busy_one_start", n_start - base, 1);
    check("busy_rx", (rx_log.size() > 0) ? rx_log[0] : 8'hXX, 8'hC5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
